// File: rtl/dec_pkg.sv
// Shared types and constants for the decode stage: instruction classes,
// opcode values, the decoded bundle layout and a source-match helper.
package dec_pkg;

  localparam int DEC_INST_W = 20;
  localparam int DEC_OP_W   = 5;
  localparam int DEC_REG_W  = 5;
  localparam int DEC_BAMT_W = DEC_INST_W - DEC_OP_W;

  localparam logic [DEC_OP_W-1:0] OP_R_MAX = 5'd6;
  localparam logic [DEC_OP_W-1:0] OP_R_ALT = 5'd11;
  localparam logic [DEC_OP_W-1:0] OP_LOAD  = 5'd12;
  localparam logic [DEC_OP_W-1:0] OP_STORE = 5'd13;

  typedef enum logic [1:0] {
    T_R     = 2'd0,
    T_LOAD  = 2'd1,
    T_STORE = 2'd2,
    T_J     = 2'd3
  } inst_type_e;

  typedef struct packed {
    inst_type_e            typ;
    logic [DEC_REG_W-1:0]  rd;
    logic [DEC_REG_W-1:0]  rt;
    logic [DEC_REG_W-1:0]  rs;
    logic [DEC_BAMT_W-1:0] bamt;
    logic                  we_rf;
    logic                  we_dmem;
  } dec_bundle_t;

  // Which bundle fields the instruction reads as source registers.
  typedef struct packed {
    logic rd;
    logic rt;
    logic rs;
  } src_use_t;

  function automatic logic src_hit(input dec_bundle_t b, input src_use_t u,
                                   input logic [DEC_REG_W-1:0] r);
    return (u.rd && (b.rd == r)) || (u.rt && (b.rt == r)) || (u.rs && (b.rs == r));
  endfunction

endpackage

// File: rtl/dec_stage_fields.sv
// Combinational instruction split and classification. Fields an instruction
// class does not use are driven to zero so every output is always defined.
module dec_fields
  import dec_pkg::*;
(
  input  logic [DEC_INST_W-1:0] inst_i,
  output dec_bundle_t           bundle_o,
  output src_use_t              use_o
);

  logic [DEC_OP_W-1:0]   op;
  logic [DEC_REG_W-1:0]  f_rd;
  logic [DEC_REG_W-1:0]  f_rt;
  logic [DEC_REG_W-1:0]  f_rs;
  logic [DEC_BAMT_W-1:0] f_bamt;

  assign op     = inst_i[DEC_INST_W-1 -: DEC_OP_W];
  assign f_rd   = inst_i[3*DEC_REG_W-1 -: DEC_REG_W];
  assign f_rt   = inst_i[2*DEC_REG_W-1 -: DEC_REG_W];
  assign f_rs   = inst_i[DEC_REG_W-1:0];
  assign f_bamt = inst_i[DEC_BAMT_W-1:0];

  always_comb begin
    bundle_o = '0;
    use_o    = '0;
    if ((op <= OP_R_MAX) || (op == OP_R_ALT)) begin
      bundle_o.typ   = T_R;
      bundle_o.rd    = f_rd;
      bundle_o.rt    = f_rt;
      bundle_o.rs    = f_rs;
      bundle_o.we_rf = 1'b1;
      use_o.rt       = 1'b1;
      use_o.rs       = 1'b1;
    end else if (op == OP_LOAD) begin
      bundle_o.typ   = T_LOAD;
      bundle_o.rd    = f_rd;
      bundle_o.rt    = f_rt;
      bundle_o.rs    = f_rs;
      bundle_o.we_rf = 1'b1;
      use_o.rt       = 1'b1;
    end else if (op == OP_STORE) begin
      bundle_o.typ     = T_STORE;
      bundle_o.rd      = f_rd;
      bundle_o.rt      = f_rt;
      bundle_o.we_dmem = 1'b1;
      use_o.rd         = 1'b1;
      use_o.rt         = 1'b1;
    end else begin
      bundle_o.typ  = T_J;
      bundle_o.bamt = f_bamt;
    end
  end

endmodule

// File: rtl/dec_stage.sv
// Registered decode stage with valid/ready on both sides, load-use bubble
// insertion, flush and a saturating count of hazard-stall cycles.
module dec_stage
  import dec_pkg::*;
#(
  parameter int INST_W  = DEC_INST_W,
  parameter int OP_W    = DEC_OP_W,
  parameter int REG_W   = DEC_REG_W,
  parameter int BAMT_W  = INST_W - OP_W,
  parameter int HAZ_GAP = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_type,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rs,
  output logic [BAMT_W-1:0] out_bamt,
  output logic              out_we_rf,
  output logic              out_we_dmem,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The bundle layout is fixed by the package, so the widths must agree.
  if (INST_W != DEC_INST_W || OP_W != DEC_OP_W || REG_W != DEC_REG_W ||
      BAMT_W != DEC_BAMT_W || HAZ_GAP < 0 || HAZ_GAP > 7 ||
      INST_W < OP_W + 3 * REG_W) begin : g_bad_param
    $error("dec_stage: widths must match dec_pkg and HAZ_GAP must be 0..7");
  end

  localparam bit       HAZ_EN  = (HAZ_GAP > 0);
  localparam logic [2:0] HAZ_ARM = (HAZ_GAP > 0) ? 3'(HAZ_GAP - 1) : 3'd0;

  dec_bundle_t dec_bundle;
  src_use_t    dec_use;

  dec_fields u_fields (
    .inst_i   (in_inst),
    .bundle_o (dec_bundle),
    .use_o    (dec_use)
  );

  logic               out_valid_q, out_valid_d;
  dec_bundle_t        bundle_q, bundle_d;
  logic [REG_W-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]         haz_cnt_q, haz_cnt_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic src_match;
  logic haz;
  logic in_fire;
  logic out_fire;

  // Two hazard sources: a load still sitting in the output register, and a
  // load that already left but whose result is not yet usable.
  always_comb begin
    src_match = 1'b0;
    if (out_valid_q && (bundle_q.typ == T_LOAD) && src_hit(dec_bundle, dec_use, bundle_q.rd))
      src_match = 1'b1;
    if ((haz_cnt_q != 3'd0) && src_hit(dec_bundle, dec_use, ld_rd_q))
      src_match = 1'b1;
  end

  assign haz      = HAZ_EN && in_valid && src_match;
  assign in_ready = (!out_valid_q || out_ready) && !haz && !flush && !reset;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    ld_rd_d     = ld_rd_q;
    haz_cnt_d   = haz_cnt_q;
    stall_d     = stall_q;

    if (haz && !flush && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);

    if (flush) begin
      // A transfer completing alongside a flush must not arm the hazard window.
      out_valid_d = 1'b0;
      haz_cnt_d   = 3'd0;
    end else begin
      if (out_fire && (bundle_q.typ == T_LOAD)) begin
        ld_rd_d   = bundle_q.rd;
        haz_cnt_d = HAZ_ARM;
      end else if (haz_cnt_q != 3'd0) begin
        haz_cnt_d = haz_cnt_q - 3'd1;
      end

      if (in_fire) begin
        bundle_d    = dec_bundle;
        out_valid_d = 1'b1;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      ld_rd_q     <= '0;
      haz_cnt_q   <= 3'd0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      ld_rd_q     <= ld_rd_d;
      haz_cnt_q   <= haz_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_type    = bundle_q.typ;
  assign out_rd      = bundle_q.rd;
  assign out_rt      = bundle_q.rt;
  assign out_rs      = bundle_q.rs;
  assign out_bamt    = bundle_q.bamt;
  assign out_we_rf   = bundle_q.we_rf;
  assign out_we_dmem = bundle_q.we_dmem;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: two instances (HAZ_GAP=1 / 16-bit counter, and
// HAZ_GAP=3 / 3-bit counter) driven in lockstep against a cycle-level model.
module tb_dec_stage;

  localparam int CW1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [19:0] in_inst;

  logic        in_ready0, out_valid0, we_rf0, we_dm0;
  logic [1:0]  type0;
  logic [4:0]  rd0, rt0, rs0;
  logic [14:0] bamt0;
  logic [15:0] stall0;

  logic           in_ready1, out_valid1, we_rf1, we_dm1;
  logic [1:0]     type1;
  logic [4:0]     rd1, rt1, rs1;
  logic [14:0]    bamt1;
  logic [CW1-1:0] stall1;

  dec_stage #(.HAZ_GAP(1)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_inst(in_inst), .out_valid(out_valid0), .out_ready(out_ready), .out_type(type0),
    .out_rd(rd0), .out_rt(rt0), .out_rs(rs0), .out_bamt(bamt0), .out_we_rf(we_rf0),
    .out_we_dmem(we_dm0), .stall_cnt(stall0)
  );

  dec_stage #(.HAZ_GAP(3), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst), .out_valid(out_valid1), .out_ready(out_ready), .out_type(type1),
    .out_rd(rd1), .out_rt(rt1), .out_rs(rs1), .out_bamt(bamt1), .out_we_rf(we_rf1),
    .out_we_dmem(we_dm1), .stall_cnt(stall1)
  );

  logic [50:0] dut_out [2];
  logic        in_ready_v [2];
  assign dut_out[0]    = {out_valid0, type0, rd0, rt0, rs0, bamt0, we_rf0, we_dm0, stall0};
  assign dut_out[1]    = {out_valid1, type1, rd1, rt1, rs1, bamt1, we_rf1, we_dm1, 13'd0, stall1};
  assign in_ready_v[0] = in_ready0;
  assign in_ready_v[1] = in_ready1;

  typedef struct {
    int typ, rd, rt, rs, bamt, we_rf, we_dm;
    bit u_rd, u_rt, u_rs;
  } mb_t;

  int  n_chk = 0, n_pass = 0, cyc = 0, deliv0 = 0;
  bit  m_valid [2];
  mb_t m_b [2];
  int  m_ld_rd [2], m_ld_cyc [2], m_stall [2];
  int  gap [2]  = '{1, 3};
  int  smax [2] = '{65535, 7};

  function automatic mb_t mdec(input logic [19:0] i);
    mb_t b;
    int op, low, f_rd, f_rt, f_rs;
    op   = int'(i) / 32768;
    low  = int'(i) % 32768;
    f_rd = low / 1024;
    f_rt = (low / 32) % 32;
    f_rs = low % 32;
    b = '{default: 0};
    if (op < 7 || op == 11) begin
      b.typ = 0; b.rd = f_rd; b.rt = f_rt; b.rs = f_rs; b.we_rf = 1; b.u_rt = 1; b.u_rs = 1;
    end else if (op == 12) begin
      b.typ = 1; b.rd = f_rd; b.rt = f_rt; b.rs = f_rs; b.we_rf = 1; b.u_rt = 1;
    end else if (op == 13) begin
      b.typ = 2; b.rd = f_rd; b.rt = f_rt; b.we_dm = 1; b.u_rd = 1; b.u_rt = 1;
    end else begin
      b.typ = 3; b.bamt = low;
    end
    return b;
  endfunction

  function automatic bit reads(input mb_t d, input int r);
    return (d.u_rd && d.rd == r) || (d.u_rt && d.rt == r) || (d.u_rs && d.rs == r);
  endfunction

  // A departed load blocks its dependants for gap-1 cycles after it leaves.
  function automatic bit m_haz(input int g);
    mb_t d;
    if (!in_valid) return 1'b0;
    d = mdec(in_inst);
    if (m_valid[g] && m_b[g].typ == 1 && reads(d, m_b[g].rd)) return 1'b1;
    if (cyc - m_ld_cyc[g] >= 1 && cyc - m_ld_cyc[g] < gap[g] && reads(d, m_ld_rd[g])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_rdy(input int g);
    return (!m_valid[g] || out_ready) && !m_haz(g) && !flush && !reset;
  endfunction

  function automatic logic [50:0] exp_out(input int g);
    mb_t b;
    b = m_b[g];
    return {m_valid[g], 2'(b.typ), 5'(b.rd), 5'(b.rt), 5'(b.rs), 15'(b.bamt),
            1'(b.we_rf), 1'(b.we_dm), 16'(m_stall[g])};
  endfunction

  // Advance the model by one clock with the inputs currently applied, then
  // move to just after the rising edge.
  task automatic tick();
    bit h, r, ofire;
    if (out_valid0 && out_ready) deliv0++;
    for (int g = 0; g < 2; g++) begin
      h = m_haz(g);
      r = m_rdy(g);
      ofire = m_valid[g] && out_ready;
      if (reset) begin
        m_valid[g] = 0; m_b[g] = '{default: 0}; m_ld_rd[g] = 0; m_ld_cyc[g] = -100; m_stall[g] = 0;
      end else begin
        if (h && !flush && m_stall[g] < smax[g]) m_stall[g]++;
        if (flush) begin
          m_valid[g] = 0;
          m_ld_cyc[g] = -100;
        end else begin
          if (ofire && m_b[g].typ == 1) begin
            m_ld_rd[g] = m_b[g].rd;
            m_ld_cyc[g] = cyc;
          end
          if (r && in_valid) begin
            m_b[g] = mdec(in_inst);
            m_valid[g] = 1;
          end else if (ofire) begin
            m_valid[g] = 0;
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Stimulus word: {reset, flush, in_valid, out_ready, inst[19:0]}
  task automatic test_reset();
    logic [23:0] st [2] = '{24'hB00C22, 24'hB71234};
    for (int k = 0; k < 2; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL reset in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== 51'd0) $display("FAIL reset outputs dut%0d cyc %0d: got %h want 0", g, cyc, dut_out[g]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_r_basic();
    logic [23:0] st [2] = '{24'h300C22, 24'h100000};
    for (int k = 0; k < 2; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL r_basic in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL r_basic model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
      if (k == 0) begin
        n_chk++;
        if (dut_out[0][50:16] !== {1'b1, 2'd0, 5'd3, 5'd1, 5'd2, 15'd0, 1'b1, 1'b0})
          $display("FAIL r_basic bundle: got %h want R rd3 rt1 rs2", dut_out[0][50:16]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] st [3] = '{24'h369C40, 24'h371234, 24'h100000};
    for (int k = 0; k < 3; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL b2b in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL b2b model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
      if (k < 2) begin
        n_chk++;
        if (dut_out[0][50:16] !== ((k == 0) ? {1'b1, 2'd2, 5'd7, 5'd2, 5'd0, 15'd0, 1'b0, 1'b1}
                                            : {1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 15'h1234, 1'b0, 1'b0}))
          $display("FAIL b2b bundle step %0d: got %h", k, dut_out[0][50:16]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load_use();
    logic [23:0] st [7] = '{24'h3610A0, 24'h301881, 24'h301881, 24'h100000,
                            24'h3610A0, 24'h3018A1, 24'h100000};
    for (int k = 0; k < 7; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL load_use in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL load_use model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
      if (k == 1) begin
        n_chk++;
        if ({out_valid0, stall0} !== {1'b0, 16'd1}) $display("FAIL load_use bubble: got valid %b stall %0d want 0 / 1", out_valid0, stall0);
        else n_pass++;
      end
      if (k == 2) begin
        n_chk++;
        if (dut_out[0][50:16] !== {1'b1, 2'd0, 5'd6, 5'd4, 5'd1, 15'd0, 1'b1, 1'b0})
          $display("FAIL load_use dependent: got %h want R rd6 rt4 rs1", dut_out[0][50:16]);
        else n_pass++;
      end
      if (k == 5) begin
        n_chk++;
        if (dut_out[0] !== {1'b1, 2'd0, 5'd6, 5'd5, 5'd1, 15'd0, 1'b1, 1'b0, 16'd1})
          $display("FAIL load_use independent: got %h want R rd6 rt5 rs1 stall 1", dut_out[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] st [6] = '{24'h300C22, 24'h271234, 24'h271234, 24'h271234, 24'h371234, 24'h100000};
    int d_start;
    d_start = 0;
    for (int k = 0; k < 6; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      if (k == 1) d_start = deliv0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL backpressure in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL backpressure model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
      if (k >= 1 && k <= 3) begin
        n_chk++;
        if (dut_out[0][50:16] !== {1'b1, 2'd0, 5'd3, 5'd1, 5'd2, 15'd0, 1'b1, 1'b0})
          $display("FAIL backpressure hold step %0d: got %h", k, dut_out[0][50:16]);
        else n_pass++;
      end
    end
    n_chk++;
    if (deliv0 - d_start !== 2) $display("FAIL backpressure transfers: got %0d want 2", deliv0 - d_start);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [23:0] st [8] = '{24'h300C22, 24'h671234, 24'h371234, 24'h100000,
                            24'h3610A0, 24'h500000, 24'h301881, 24'h100000};
    for (int k = 0; k < 8; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL flush in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL flush model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
      if (k == 1) begin
        n_chk++;
        if (out_valid0 !== 1'b0) $display("FAIL flush drop: got valid %b want 0", out_valid0);
        else n_pass++;
      end
      if (k == 2) begin
        n_chk++;
        if (dut_out[0][50:16] !== {1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 15'h1234, 1'b0, 1'b0})
          $display("FAIL flush retry: got %h want J 1234", dut_out[0][50:16]);
        else n_pass++;
      end
      if (k == 6) begin
        n_chk++;
        if (out_valid1 !== 1'b1) $display("FAIL flush no_arm: got valid %b want 1", out_valid1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_hazard();
    logic [23:0] st [5] = '{24'h3610A0, 24'h301881, 24'hB01881, 24'h301881, 24'h100000};
    for (int k = 0; k < 5; k++) begin
      {reset, flush, in_valid, out_ready, in_inst} = st[k];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL rst_haz in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if (in_ready1 !== 1'b1) $display("FAIL rst_haz accept: got in_ready %b want 1", in_ready1);
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL rst_haz model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
      if (k == 2) begin
        n_chk++;
        if (dut_out[1] !== 51'd0) $display("FAIL rst_haz clear: got %h want 0", dut_out[1]);
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if (dut_out[1] !== {1'b1, 2'd0, 5'd6, 5'd4, 5'd1, 15'd0, 1'b1, 1'b0, 16'd0})
          $display("FAIL rst_haz dependent: got %h want R rd6 rt4 rs1 stall 0", dut_out[1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int op, low;
    for (int k = 0; k < 800; k++) begin
      case ($urandom_range(0, 3))
        0: op = 12;
        1: op = 13;
        default: op = $urandom_range(0, 31);
      endcase
      low = $urandom_range(0, 32767);
      if ($urandom_range(0, 3) != 0) low = low & 32'h0C63;
      in_inst   = {5'(op), 15'(low)};
      reset     = ($urandom_range(0, 149) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (in_ready_v[g] !== m_rdy(g)) $display("FAIL random in_ready dut%0d cyc %0d: got %b want %b", g, cyc, in_ready_v[g], m_rdy(g));
        else n_pass++;
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        n_chk++;
        if (dut_out[g] !== exp_out(g)) $display("FAIL random model dut%0d cyc %0d: got %h want %h", g, cyc, dut_out[g], exp_out(g));
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
    for (int g = 0; g < 2; g++) begin
      m_valid[g] = 0; m_b[g] = '{default: 0}; m_ld_rd[g] = 0; m_ld_cyc[g] = -100; m_stall[g] = 0;
    end
    test_reset();
    test_r_basic();
    test_back_to_back();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid_hazard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
